// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: scans BCD digits into 16-bit 595 frames {dp,g..a, one-hot select} with a 1-cycle trigger.
// Define HEX_DIGITS_EN to decode codes 10-15 as A,b,C,d,E,F; otherwise those codes are blank.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    blank_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    output logic [15:0]             frame_o,
    output logic                    trigger_o,
    output logic [2:0]              digit_idx_o
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);
    typedef enum logic [1:0] {S_COUNT, S_LOAD, S_FIRE} state_t;
    state_t        r_state, w_next;
    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic [15:0]   r_frame;
    logic          r_trig;
    logic [2:0]    r_idx_out;
    logic [3:0]    w_digit;
    logic          w_dp;
    logic [6:0]    w_seg;
    always_comb begin
        w_digit = '0;
        w_dp    = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == 3'(k)) begin
                w_digit = digits_i[4*k +: 4];
                w_dp    = dp_i[k];
            end
        end
    end
    always_comb begin
        w_seg = 7'h00;
        case (w_digit)
            4'd0: w_seg = 7'h3F;
            4'd1: w_seg = 7'h06;
            4'd2: w_seg = 7'h5B;
            4'd3: w_seg = 7'h4F;
            4'd4: w_seg = 7'h66;
            4'd5: w_seg = 7'h6D;
            4'd6: w_seg = 7'h7D;
            4'd7: w_seg = 7'h07;
            4'd8: w_seg = 7'h7F;
            4'd9: w_seg = 7'h6F;
`ifdef HEX_DIGITS_EN
            4'd10: w_seg = 7'h77;
            4'd11: w_seg = 7'h7C;
            4'd12: w_seg = 7'h39;
            4'd13: w_seg = 7'h5E;
            4'd14: w_seg = 7'h79;
            4'd15: w_seg = 7'h71;
`endif
            default: w_seg = 7'h00;
        endcase
    end
    always_comb begin
        w_next = S_COUNT;
        case (r_state)
            S_COUNT: w_next = (enable_i && r_presc == LAST) ? S_LOAD : S_COUNT;
            S_LOAD:  w_next = S_FIRE;
            default: w_next = S_COUNT;
        endcase
    end
    // Prescaler is only live in COUNT and is already zero when LOAD/FIRE run.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_COUNT;
            r_presc   <= '0;
            r_idx     <= '0;
            r_frame   <= '0;
            r_trig    <= 1'b0;
            r_idx_out <= '0;
        end else begin
            r_state <= w_next;
            r_trig  <= (r_state == S_LOAD);
            if (r_state == S_COUNT)
                r_presc <= (enable_i && r_presc != LAST) ? r_presc + 1'b1 : '0;
            if (r_state == S_LOAD) begin
                r_frame   <= {blank_i ? 8'h00 : {w_dp, w_seg}, 8'(1) << r_idx};
                r_idx_out <= r_idx;
                r_idx     <= (r_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
            end
        end
    end
    assign frame_o     = r_frame;
    assign trigger_o   = r_trig;
    assign digit_idx_o = r_idx_out;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: directed checks of scan timing, decode, blanking, enable hold and reset abort.
module tb_seven_seg_scan_driver;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        enable_i = 1'b0;
    logic        blank_i = 1'b0;
    logic [15:0] digits_i = '0;
    logic [3:0]  dp_i = '0;
    logic [15:0] frame_o;
    logic        trigger_o;
    logic [2:0]  digit_idx_o;
    int checks = 0;
    int errors = 0;
    int n;
    logic saw_trig;
    seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(40)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .blank_i(blank_i),
        .digits_i(digits_i), .dp_i(dp_i), .frame_o(frame_o),
        .trigger_o(trigger_o), .digit_idx_o(digit_idx_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic run_to_trig(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk_i);
            #1;
            cnt++;
        end while (!trigger_o && cnt < 300);
    endtask
    task automatic pulse(input string tag, input int gap, input logic [15:0] frame, input logic [2:0] idx);
        run_to_trig(n);
        chk({tag, "_gap"}, 16'(n), 16'(gap));
        chk({tag, "_frame"}, frame_o, frame);
        chk({tag, "_idx"}, 16'(digit_idx_o), 16'(idx));
        @(posedge clk_i);
        #1;
        chk({tag, "_trig_drop"}, 16'(trigger_o), 16'h0);
        chk({tag, "_hold"}, frame_o, frame);
    endtask
    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask
    initial begin
        #2 rst_i = 1'b1;
        #1;
        chk("rst_frame", frame_o, 16'h0000);
        chk("rst_trig", 16'(trigger_o), 16'h0);
        chk("rst_idx", 16'(digit_idx_o), 16'h0);
        enable_i = 1'b1;
        digits_i = 16'h1234;
        do_reset();
        pulse("p0", 41, 16'h6601, 3'd0);
        pulse("p1", 41, 16'h4F02, 3'd1);
        pulse("p2", 41, 16'h5B04, 3'd2);
        pulse("p3", 41, 16'h0608, 3'd3);
        pulse("p4", 41, 16'h6601, 3'd0);
        dp_i = 4'b0010;
        blank_i = 1'b1;
        pulse("blank1", 41, 16'h0002, 3'd1);
        blank_i = 1'b0;
        pulse("unblank2", 41, 16'h5B04, 3'd2);
        pulse("dp3", 41, 16'h0608, 3'd3);
        pulse("dp0", 41, 16'h6601, 3'd0);
        pulse("dp1", 41, 16'hCF02, 3'd1);
        dp_i = 4'b0000;
        digits_i = 16'h00AF;
        do_reset();
`ifdef HEX_DIGITS_EN
        pulse("hexF", 41, 16'h7101, 3'd0);
        pulse("hexA", 41, 16'h7702, 3'd1);
`else
        pulse("hexF", 41, 16'h0001, 3'd0);
        pulse("hexA", 41, 16'h0002, 3'd1);
`endif
        digits_i = 16'h5678;
        pulse("d6", 41, 16'h7D04, 3'd2);
        pulse("d5", 41, 16'h6D08, 3'd3);
        pulse("d8", 41, 16'h7F01, 3'd0);
        pulse("d7", 41, 16'h0702, 3'd1);
        repeat (10) @(negedge clk_i);
        enable_i = 1'b0;
        saw_trig = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_i);
            #1;
            saw_trig |= trigger_o;
        end
        chk("dis_no_trig", 16'(saw_trig), 16'h0);
        chk("dis_frame_held", frame_o, 16'h0702);
        chk("dis_idx_held", 16'(digit_idx_o), 16'h1);
        enable_i = 1'b1;
        run_to_trig(n);
        chk("reen_gap", 16'(n), 16'd41);
        chk("reen_frame", frame_o, 16'h7D04);
        chk("reen_idx", 16'(digit_idx_o), 16'h2);
        digits_i = 16'h1234;
        run_to_trig(n);
        chk("fire_gap", 16'(n), 16'd42);
        #2 rst_i = 1'b1;
        #1;
        chk("fire_rst_trig", 16'(trigger_o), 16'h0);
        chk("fire_rst_frame", frame_o, 16'h0000);
        chk("fire_rst_idx", 16'(digit_idx_o), 16'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        pulse("after_rst", 41, 16'h6601, 3'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
